// File: rtl/transmit_packet_pkg.sv
// Shared types and constants for the RAM-to-MAC packet transmitter.
package transmit_packet_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WAIT, ST_SEND, ST_FIN} state_e;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 4096;
  localparam int LEN_W   = 13;
endpackage

// File: rtl/transmit_packet_serializer.sv
// Serialises one captured 32-bit RAM word into byte beats with sop/eop/err.
module tx_byte_serializer
  import transmit_packet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  nbytes_i,
  input  logic        first_i,
  input  logic        final_i,
  input  logic        abort_q_i,
  input  logic        abort_now_i,
  input  logic        rdy_i,
  output logic [7:0]  data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic        wren_o,
  output logic        err_o,
  output logic        word_done_o
);
  localparam int LW = $clog2(LANES);

  logic [31:0]   hold_q, hold_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic          first_q, first_d;
  logic          final_q, final_d;
  logic          valid_q, valid_d;

  logic [LANES-1:0][7:0] lanes_w;
  logic word_end, xfer, last_beat;

  assign lanes_w   = hold_q;
  assign word_end  = ({1'b0, lane_q} == (nbytes_q - 3'd1));
  assign xfer      = valid_q & rdy_i;
  // A registered abort makes whichever beat is on offer the last one.
  assign last_beat = word_end | abort_q_i;

  always_comb begin
    hold_d   = hold_q;
    lane_d   = lane_q;
    nbytes_d = nbytes_q;
    first_d  = first_q;
    final_d  = final_q;
    valid_d  = valid_q;
    if (load_i) begin
      hold_d   = word_i;
      lane_d   = '0;
      nbytes_d = nbytes_i;
      first_d  = first_i;
      final_d  = final_i;
      valid_d  = 1'b1;
    end else if (xfer) begin
      if (last_beat) valid_d = 1'b0;
      else           lane_d  = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      lane_q   <= '0;
      nbytes_q <= '0;
      first_q  <= 1'b0;
      final_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      lane_q   <= lane_d;
      nbytes_q <= nbytes_d;
      first_q  <= first_d;
      final_q  <= final_d;
      valid_q  <= valid_d;
    end
  end

  assign wren_o      = valid_q;
  assign data_o      = valid_q ? lanes_w[lane_q] : 8'h00;
  assign sop_o       = valid_q & first_q & (lane_q == '0);
  assign eop_o       = valid_q & ((word_end & final_q) | abort_q_i);
  // Abort coinciding with the natural last byte still flags that byte.
  assign err_o       = valid_q & (abort_q_i | (abort_now_i & word_end & final_q));
  assign word_done_o = xfer & last_beat;
endmodule

// File: rtl/transmit_packet.sv
// Fetches a packet word-by-word from an Avalon-MM RAM and streams it as bytes.
module transmit_packet
  import transmit_packet_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [RAM_AW-1:0] tx_base,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic              tx_abort,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_chipselect,
  output logic              ram_read,
  input  logic [31:0]       ram_readdata,
  output logic [7:0]        ff_tx_data,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic              ff_tx_wren,
  output logic              ff_tx_err,
  output logic              ff_tx_crc_fwd,
  input  logic              ff_tx_rdy
);
  state_e            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        wait_q, wait_d;
  logic              abort_q, abort_d;
  logic              first_q, first_d;

  logic [LEN_W-1:0] len_clamped;
  logic [2:0]       nbytes_w;
  logic             final_w, load_w, word_done_w;

  assign len_clamped = (tx_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tx_len;
  assign nbytes_w    = (rem_q >= LEN_W'(LANES)) ? 3'(LANES) : rem_q[2:0];
  assign final_w     = (rem_q <= LEN_W'(LANES));
  assign load_w      = (state_q == ST_WAIT) && (wait_q == 2'(RD_LATENCY - 1));

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tx_start) state_d = (tx_len != '0) ? ST_RD : ST_FIN;
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: if (load_w) state_d = ST_SEND;
      // rem_q already excludes the word being sent, so zero means last word.
      ST_SEND: if (word_done_w) state_d = (abort_q || rem_q == '0) ? ST_FIN : ST_RD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_busy        = (state_q != ST_IDLE);
    tx_done        = (state_q == ST_FIN);
    ram_read       = (state_q == ST_RD);
    ram_chipselect = (state_q == ST_RD);
    ram_addr       = (state_q == ST_RD) ? addr_q : '0;
    ff_tx_crc_fwd  = 1'b0;
  end

  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    abort_d = abort_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE: if (tx_start) begin
        addr_d  = tx_base;
        rem_d   = len_clamped;
        abort_d = 1'b0;
        first_d = 1'b1;
      end
      ST_RD: begin
        addr_d = addr_q + 1'b1;
        wait_d = '0;
      end
      ST_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (load_w) begin
          rem_d   = rem_q - LEN_W'(nbytes_w);
          first_d = 1'b0;
        end
      end
      ST_FIN:  abort_d = 1'b0;
      default: ;
    endcase
    if (tx_abort && (state_q == ST_RD || state_q == ST_WAIT || state_q == ST_SEND))
      abort_d = 1'b1;
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      abort_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      first_q <= first_d;
    end
  end

  tx_byte_serializer u_ser (
    .clk         (clk_original),
    .rst         (rst),
    .load_i      (load_w),
    .word_i      (ram_readdata),
    .nbytes_i    (nbytes_w),
    .first_i     (first_q),
    .final_i     (final_w),
    .abort_q_i   (abort_q),
    .abort_now_i (tx_abort && state_q == ST_SEND),
    .rdy_i       (ff_tx_rdy),
    .data_o      (ff_tx_data),
    .sop_o       (ff_tx_sop),
    .eop_o       (ff_tx_eop),
    .wren_o      (ff_tx_wren),
    .err_o       (ff_tx_err),
    .word_done_o (word_done_w)
  );
endmodule

// File: doc/transmit_packet.md
TRANSMIT_PACKET -- requirements
Module: transmit_packet

Interface
REQ-001 Parameter RAM_AW, default 10: RAM word-address width.
REQ-002 Parameter RD_LATENCY, default 1, legal values 1..2: fixed cycles from RAM read strobe to valid ram_readdata.
REQ-003 clk_original  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 tx_start  in  1  one-cycle pulse that launches a packet.
REQ-006 tx_base  in  RAM_AW  word address of the first packet word, sampled on tx_start.
REQ-007 tx_len  in  13  packet length in bytes, sampled on tx_start.
REQ-008 tx_abort  in  1  request to terminate the current packet with error.
REQ-009 tx_busy  out  1  packet in progress.
REQ-010 tx_done  out  1  one-cycle pulse when the packet has ended.
REQ-011 ram_addr  out  RAM_AW  Avalon-MM word address.
REQ-012 ram_chipselect  out  1  Avalon-MM chipselect.
REQ-013 ram_read  out  1  Avalon-MM read strobe.
REQ-014 ram_readdata  in  32  Avalon-MM read data.
REQ-015 ff_tx_data  out  8  Avalon-ST data towards the MAC transmit FIFO.
REQ-016 ff_tx_sop  out  1  start of packet.
REQ-017 ff_tx_eop  out  1  end of packet.
REQ-018 ff_tx_wren  out  1  valid.
REQ-019 ff_tx_err  out  1  error flag, qualified by eop.
REQ-020 ff_tx_crc_fwd  out  1  tied 0; the MAC appends the CRC.
REQ-021 ff_tx_rdy  in  1  sink ready.

Function
REQ-022 A beat transfers on a cycle where ff_tx_wren=1 and ff_tx_rdy=1.
- While ff_tx_wren=1 and ff_tx_rdy=0: data, sop, eop and err are held stable.

REQ-023 The state machine has states IDLE, RD, WAIT, SEND and FIN.
- IDLE to RD: on tx_start when tx_len is nonzero.
- RD to WAIT: after issuing one read.
- WAIT to SEND: after RD_LATENCY cycles, when the word is captured into a 32-bit holding register.
- SEND to RD: when 4 bytes have transferred and more remain.
- SEND to FIN: when the last byte has transferred.
- FIN to IDLE: after 1 cycle.

REQ-024 tx_start is ignored while tx_busy=1.
- tx_len=0 issues no RAM or stream traffic and produces a tx_done pulse 1 cycle after tx_start.

REQ-025 tx_len values above 4096 are treated as 4096.

REQ-026 RAM access:
- ram_read and ram_chipselect are high for exactly 1 cycle, in RD only.
- The word address starts at tx_base and increments by 1 per word.
- The address wraps from 2^RAM_AW-1 to 0.

REQ-027 Byte order: bytes go out as readdata[7:0], [15:8], [23:16], [31:24].
- The final word sends only ((tx_len-1) mod 4)+1 bytes.

REQ-028 ff_tx_sop=1 only on the first byte; ff_tx_eop=1 only on the last byte.
- A 1-byte packet has sop=eop=1 on the same beat.

REQ-029 tx_busy=1 from the cycle after an accepted tx_start through FIN inclusive.
- tx_done pulses in FIN.

REQ-030 tx_abort while in RD or WAIT:
- The pending word still completes.
- Its first byte goes out as the final beat with eop=1 and err=1.

REQ-031 tx_abort while in SEND:
- The next beat offered is the final beat, with eop=1 and err=1.
- If a beat is currently held under back-pressure, that held beat is converted to eop=1, err=1; its data stays unchanged.

REQ-032 tx_abort asserted together with the natural last byte yields eop=1 with err=1.
- tx_abort in IDLE or FIN is ignored.

REQ-033 Throughput: 4 bytes per (4 + 1 + RD_LATENCY) cycles under continuous ff_tx_rdy; no read-ahead is performed.

Reset
REQ-034 While rst=1, all outputs are 0 and the state is IDLE.
REQ-035 A reset mid-packet truncates the stream without eop; upstream recovers by resetting the MAC FIFO.
REQ-036 After rst deasserts, tx_start is accepted in the first clock cycle.

Structure
REQ-037 A shared package holds:
- the state enumeration;
- the byte-lane count (4);
- the maximum length constant (4096).

REQ-038 Byte serialisation (holding register, lane counter, sop/eop generation) sits in one sub-module, tx_byte_serializer; sequencing and RAM control sit in the top module.

Verification
REQ-039 tx_base=0x010, tx_len=8, ff_tx_rdy=1 -> reads at 0x010 and 0x011; bytes 0..7 in lane order; sop on byte 0, eop on byte 7; tx_done once.
REQ-040 tx_len=5, RAM word1=0xDDCCBBAA -> 5 beats; the last beat carries 0xAA with eop=1.
REQ-041 tx_base=0x3FF, tx_len=8 -> ram_addr is 0x3FF and then 0x000.
REQ-042 ff_tx_rdy toggled at random over tx_len=64 -> 64 accepted beats; held beats are stable; data matches RAM.
REQ-043 tx_abort on the 3rd accepted beat of tx_len=16 -> the 4th beat has eop=1, err=1; tx_done follows; no further reads.
REQ-044 rst asserted mid-packet, then tx_len=0 start -> outputs are 0 immediately; tx_done pulses with no ram_read and no ff_tx_wren.
